// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, shift/immediate operand
// selection and load-use hazard detection for the five-stage MIPS pipeline.
module ex_operand_stage (
  input  logic        clock,
  input  logic        resetn,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_da,
  input  logic [31:0] id_db,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_sa,
  input  logic [3:0]  id_aluc,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rn,
  input  logic        id_wreg,
  input  logic        id_m2reg,
  input  logic        id_wmem,
  input  logic        id_aluimm,
  input  logic        id_shift,
  input  logic        id_jal,
  input  logic [31:0] id_pc4,
  input  logic [4:0]  mem_rn,
  input  logic        mem_wreg,
  input  logic        mem_m2reg,
  input  logic [31:0] mem_alu,
  input  logic [4:0]  wb_rn,
  input  logic        wb_wreg,
  input  logic [31:0] wb_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_c,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rn,
  output logic        ex_wreg,
  output logic        ex_m2reg,
  output logic        ex_wmem,
  output logic        ex_jal,
  output logic        ex_valid,
  output logic [31:0] ex_pc8,
  output logic        load_use
);

  logic [31:0] ex_da;
  logic [31:0] ex_db;
  logic [31:0] ex_imm;
  logic [4:0]  ex_sa;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic        ex_aluimm;
  logic        ex_shift;

  logic        mem_fwd_a;
  logic        mem_fwd_b;
  logic        wb_fwd_a;
  logic        wb_fwd_b;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  // MEM-stage loads have no data yet, so only ALU results are taken from MEM.
  assign mem_fwd_a = mem_wreg & ~mem_m2reg & (mem_rn == ex_rs) & (ex_rs != 5'd0);
  assign mem_fwd_b = mem_wreg & ~mem_m2reg & (mem_rn == ex_rt) & (ex_rt != 5'd0);
  assign wb_fwd_a  = wb_wreg & (wb_rn == ex_rs) & (ex_rs != 5'd0);
  assign wb_fwd_b  = wb_wreg & (wb_rn == ex_rt) & (ex_rt != 5'd0);

  always_comb begin
    fwd_a = ex_da;
    if (mem_fwd_a)
      fwd_a = mem_alu;
    else if (wb_fwd_a)
      fwd_a = wb_data;
  end

  always_comb begin
    fwd_b = ex_db;
    if (mem_fwd_b)
      fwd_b = mem_alu;
    else if (wb_fwd_b)
      fwd_b = wb_data;
  end

  assign alu_a         = ex_shift  ? {27'b0, ex_sa} : fwd_a;
  assign alu_b         = ex_aluimm ? ex_imm         : fwd_b;
  assign ex_store_data = fwd_b;

  assign load_use = ex_valid & ex_wreg & ex_m2reg & (ex_rn != 5'd0) &
                    ((ex_rn == id_rs) | (ex_rn == id_rt));

  // While stalled the operands are refreshed so they outlive their producer.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ex_valid  <= 1'b0;
      ex_da     <= '0;
      ex_db     <= '0;
      ex_imm    <= '0;
      ex_sa     <= '0;
      alu_c     <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rn     <= '0;
      ex_wreg   <= 1'b0;
      ex_m2reg  <= 1'b0;
      ex_wmem   <= 1'b0;
      ex_aluimm <= 1'b0;
      ex_shift  <= 1'b0;
      ex_jal    <= 1'b0;
      ex_pc8    <= '0;
    end else if (flush) begin
      ex_valid  <= 1'b0;
      ex_da     <= '0;
      ex_db     <= '0;
      ex_imm    <= '0;
      ex_sa     <= '0;
      alu_c     <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rn     <= '0;
      ex_wreg   <= 1'b0;
      ex_m2reg  <= 1'b0;
      ex_wmem   <= 1'b0;
      ex_aluimm <= 1'b0;
      ex_shift  <= 1'b0;
      ex_jal    <= 1'b0;
      ex_pc8    <= '0;
    end else if (stall) begin
      ex_da <= fwd_a;
      ex_db <= fwd_b;
    end else begin
      ex_valid  <= id_valid;
      ex_da     <= id_da;
      ex_db     <= id_db;
      ex_imm    <= id_imm;
      ex_sa     <= id_sa;
      alu_c     <= id_aluc;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rn     <= id_rn;
      ex_wreg   <= id_wreg;
      ex_m2reg  <= id_m2reg;
      ex_wmem   <= id_wmem;
      ex_aluimm <= id_aluimm;
      ex_shift  <= id_shift;
      ex_jal    <= id_jal;
      ex_pc8    <= id_pc4 + 32'd4;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_ex_operand_stage;

  logic        clock;
  logic        resetn;
  logic        stall, flush, id_valid;
  logic [31:0] id_da, id_db, id_imm, id_pc4;
  logic [4:0]  id_sa, id_rs, id_rt, id_rn;
  logic [3:0]  id_aluc;
  logic        id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_jal;
  logic [4:0]  mem_rn, wb_rn;
  logic        mem_wreg, mem_m2reg, wb_wreg;
  logic [31:0] mem_alu, wb_data;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc8;
  logic [3:0]  alu_c;
  logic [4:0]  ex_rn;
  logic        ex_wreg, ex_m2reg, ex_wmem, ex_jal, ex_valid, load_use;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  ex_operand_stage dut (
    .clock(clock), .resetn(resetn), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_da(id_da), .id_db(id_db), .id_imm(id_imm),
    .id_sa(id_sa), .id_aluc(id_aluc), .id_rs(id_rs), .id_rt(id_rt), .id_rn(id_rn),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .id_aluimm(id_aluimm), .id_shift(id_shift), .id_jal(id_jal), .id_pc4(id_pc4),
    .mem_rn(mem_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_alu(mem_alu),
    .wb_rn(wb_rn), .wb_wreg(wb_wreg), .wb_data(wb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .ex_store_data(ex_store_data),
    .ex_rn(ex_rn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_jal(ex_jal), .ex_valid(ex_valid), .ex_pc8(ex_pc8), .load_use(load_use)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural view of the instruction sitting in EX.
  typedef struct packed {
    logic        valid;
    logic [31:0] da, db, imm, pc8;
    logic [4:0]  sa, rs, rt, rn;
    logic [3:0]  aluc;
    logic        wreg, m2reg, wmem, aluimm, shift, jal;
  } ex_t;

  ex_t m;

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] regval);
    if (idx == 5'd0) return regval;
    if (mem_wreg && !mem_m2reg && mem_rn == idx) return mem_alu;
    if (wb_wreg && wb_rn == idx) return wb_data;
    return regval;
  endfunction

  always @(posedge clock or negedge resetn) begin : model
    ex_t n;
    n = m;
    if (!resetn || flush) begin
      n = '0;
    end else if (stall) begin
      n.da = operand(m.rs, m.da);
      n.db = operand(m.rt, m.db);
    end else begin
      n.valid = id_valid;   n.da = id_da;         n.db = id_db;
      n.imm = id_imm;       n.sa = id_sa;         n.aluc = id_aluc;
      n.rs = id_rs;         n.rt = id_rt;         n.rn = id_rn;
      n.wreg = id_wreg;     n.m2reg = id_m2reg;   n.wmem = id_wmem;
      n.aluimm = id_aluimm; n.shift = id_shift;   n.jal = id_jal;
      n.pc8 = id_pc4 + 32'd4;
    end
    m <= n;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  logic [31:0] exp_a, exp_b, exp_st;
  logic        exp_lu;

  always @(negedge clock) begin
    if (check_en) begin
      exp_st = operand(m.rt, m.db);
      exp_a  = m.shift ? {27'b0, m.sa} : operand(m.rs, m.da);
      exp_b  = m.aluimm ? m.imm : exp_st;
      exp_lu = m.valid && m.wreg && m.m2reg && m.rn != 5'd0 && (m.rn == id_rs || m.rn == id_rt);
      checkOutput("model alu_a", alu_a, exp_a);
      checkOutput("model alu_b", alu_b, exp_b);
      checkOutput("model store_data", ex_store_data, exp_st);
      checkOutput("model alu_c", 32'(alu_c), 32'(m.aluc));
      checkOutput("model ex_rn", 32'(ex_rn), 32'(m.rn));
      checkOutput("model ctrl", 32'({ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_jal}),
                  32'({m.valid, m.wreg, m.m2reg, m.wmem, m.jal}));
      checkOutput("model ex_pc8", ex_pc8, m.pc8);
      checkOutput("model load_use", 32'(load_use), 32'(exp_lu));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setIdle();
    stall = 0; flush = 0; id_valid = 0;
    id_da = '0; id_db = '0; id_imm = '0; id_pc4 = '0;
    id_sa = '0; id_rs = '0; id_rt = '0; id_rn = '0; id_aluc = '0;
    id_wreg = 0; id_m2reg = 0; id_wmem = 0; id_aluimm = 0; id_shift = 0; id_jal = 0;
    mem_rn = '0; mem_wreg = 0; mem_m2reg = 0; mem_alu = '0;
    wb_rn = '0; wb_wreg = 0; wb_data = '0;
  endtask

  // Small register indices make forwarding and load-use hits frequent.
  task automatic applyStimulus();
    stall     = ($urandom_range(0, 5) == 0);
    flush     = ($urandom_range(0, 11) == 0);
    id_valid  = 1'($urandom_range(0, 1));
    id_da     = $urandom;
    id_db     = $urandom;
    id_imm    = $urandom;
    id_pc4    = $urandom;
    id_sa     = 5'($urandom_range(0, 31));
    id_aluc   = 4'($urandom_range(0, 15));
    id_rs     = 5'($urandom_range(0, 3));
    id_rt     = 5'($urandom_range(0, 3));
    id_rn     = 5'($urandom_range(0, 3));
    id_wreg   = 1'($urandom_range(0, 1));
    id_m2reg  = 1'($urandom_range(0, 1));
    id_wmem   = 1'($urandom_range(0, 1));
    id_aluimm = ($urandom_range(0, 3) == 0);
    id_shift  = ($urandom_range(0, 3) == 0);
    id_jal    = 1'($urandom_range(0, 1));
    mem_rn    = 5'($urandom_range(0, 3));
    mem_wreg  = 1'($urandom_range(0, 1));
    mem_m2reg = 1'($urandom_range(0, 1));
    mem_alu   = $urandom;
    wb_rn     = 5'($urandom_range(0, 3));
    wb_wreg   = 1'($urandom_range(0, 1));
    wb_data   = $urandom;
  endtask

  initial begin
    setIdle();
    resetn = 0;
    repeat (3) tick();
    resetn = 1;
    check_en = 1;
    checkOutput("reset alu_c", 32'(alu_c), 32'h0);
    checkOutput("reset ex_pc8", ex_pc8, 32'h0);

    // Capture latency and link address
    id_valid = 1; id_pc4 = 32'h0040_0004;
    tick();
    checkOutput("pc8 capture", ex_pc8, 32'h0040_0008);

    // MEM beats WB, WB used when MEM drops, register 0 never forwarded
    setIdle(); id_valid = 1; id_rs = 5'd8; id_da = 32'h5555;
    tick();
    mem_rn = 5'd8; mem_wreg = 1; mem_alu = 32'h11;
    wb_rn = 5'd8; wb_wreg = 1; wb_data = 32'h22;
    #1 checkOutput("fwd mem", alu_a, 32'h11);
    mem_wreg = 0;
    #1 checkOutput("fwd wb", alu_a, 32'h22);
    id_rs = 5'd0; id_da = 32'h777; mem_rn = 5'd0; mem_wreg = 1; wb_rn = 5'd0;
    tick();
    checkOutput("fwd r0", alu_a, 32'h777);

    // Shift and immediate operands, store data still forwarded
    setIdle(); id_valid = 1; id_shift = 1; id_sa = 5'd31; id_aluimm = 1;
    id_imm = 32'hFFFF_8000; id_rt = 5'd5; id_db = 32'h1234;
    tick();
    wb_rn = 5'd5; wb_wreg = 1; wb_data = 32'hBEEF;
    #1 checkOutput("shift alu_a", alu_a, 32'h1F);
    checkOutput("imm alu_b", alu_b, 32'hFFFF_8000);
    checkOutput("imm store_data", ex_store_data, 32'hBEEF);

    // Load-use detection
    setIdle(); id_valid = 1; id_wreg = 1; id_m2reg = 1; id_rn = 5'd9;
    tick();
    id_valid = 0; id_wreg = 0; id_m2reg = 0; id_rn = 0; id_rs = 5'd9;
    #1 checkOutput("load_use rs", 32'(load_use), 32'h1);
    id_rs = 5'd3; id_rt = 5'd9;
    #1 checkOutput("load_use rt", 32'(load_use), 32'h1);
    id_valid = 1; id_wreg = 1; id_m2reg = 1; id_rn = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    tick();
    id_valid = 0; id_rs = 5'd0;
    #1 checkOutput("load_use r0", 32'(load_use), 32'h0);

    // MEM load is not a forwarding source
    setIdle(); id_valid = 1; id_rs = 5'd7; id_da = 32'h70;
    tick();
    mem_rn = 5'd7; mem_wreg = 1; mem_m2reg = 1; mem_alu = 32'h99;
    #1 checkOutput("no mem load fwd", alu_a, 32'h70);

    // Stall refresh keeps the forwarded operand after its source disappears
    setIdle(); id_valid = 1; id_rs = 5'd10; id_da = 32'h1;
    tick();
    mem_rn = 5'd10; mem_wreg = 1; mem_alu = 32'hABCD; stall = 1;
    #1 checkOutput("refresh start", alu_a, 32'hABCD);
    tick();
    mem_wreg = 0; wb_wreg = 0; id_da = 32'hDEAD; id_rs = 5'd2;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("refresh hold", alu_a, 32'hABCD);
      tick();
    end
    stall = 0;

    // Flush beats stall
    setIdle(); id_valid = 1; id_wreg = 1; id_wmem = 1; id_aluc = 4'd5;
    tick();
    flush = 1; stall = 1;
    tick();
    checkOutput("flush valid", 32'(ex_valid), 32'h0);
    checkOutput("flush wreg", 32'(ex_wreg), 32'h0);
    checkOutput("flush wmem", 32'(ex_wmem), 32'h0);
    checkOutput("flush alu_c", 32'(alu_c), 32'h0);

    // Asynchronous reset in the middle of a stall
    setIdle(); id_valid = 1; id_wreg = 1; id_m2reg = 1; id_rn = 5'd4;
    id_pc4 = 32'h1000; id_da = 32'h42; id_aluc = 4'd9;
    tick();
    stall = 1; id_rs = 5'd4;
    #2 resetn = 0;
    #1 checkOutput("async rst alu_a", alu_a, 32'h0);
    checkOutput("async rst ex_pc8", ex_pc8, 32'h0);
    checkOutput("async rst load_use", 32'(load_use), 32'h0);
    checkOutput("async rst valid", 32'(ex_valid), 32'h0);
    tick();
    setIdle();
    resetn = 1;
    id_valid = 1; id_pc4 = 32'h0040_0004;
    tick();
    checkOutput("pc8 after reset", ex_pc8, 32'h0040_0008);

    // Randomized traffic checked by the per-cycle model comparison
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      tick();
    end

    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
